// File: rtl/bus_interface_unit_ws.sv
// Registered bus interface unit: decodes CPU load/store/IN/OUT requests into MEM or IO
// bus accesses with programmable wait states, ready extension, stall timeout and error reporting.
module bus_interface_unit_ws #(
   parameter int                    DATA_WIDTH      = 8,
   parameter int                    ADDR_WIDTH      = 16,
   parameter logic [ADDR_WIDTH-1:0] IO_START_ADDR   = 16'h0000,
   parameter logic [ADDR_WIDTH-1:0] IO_STOP_ADDR    = 16'h003F,
   parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR  = 16'h0040,
   parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR   = 16'h00BF,
   parameter int                    MEM_WAIT_STATES = 0,
   parameter int                    IO_WAIT_STATES  = 1,
   parameter int                    TIMEOUT_CYCLES  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   inout  wire  [DATA_WIDTH-1:0] bus_data,
   input  logic                  bus_ready,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic                  io_cs,
   output logic                  io_we,
   output logic                  io_oe
);

   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0]         STALL_LAST = SW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] MEM_SPAN   = MEM_STOP_ADDR - MEM_START_ADDR;
   localparam logic [ADDR_WIDTH-1:0] IO_SPAN    = IO_STOP_ADDR - IO_START_ADDR;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    lat_we;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic                    region_mem;
   logic                    err_flag;
   logic [3:0]              wait_cnt;
   logic [SW-1:0]           stall_cnt;
   logic [ADDR_WIDTH-1:0]   rel_mem;
   logic [ADDR_WIDTH-1:0]   rel_io;
   logic                    in_mem;
   logic                    in_io;
   logic                    in_access;
   logic                    timed_out;

   // Offset-and-compare range check avoids a constant compare when a region starts at 0.
   assign rel_mem   = req_addr - MEM_START_ADDR;
   assign rel_io    = req_addr - IO_START_ADDR;
   assign in_mem    = (rel_mem <= MEM_SPAN);
   assign in_io     = (rel_io <= IO_SPAN);
   assign timed_out = (stall_cnt == STALL_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req) begin
               state_next = (in_mem || in_io) ? ACCESS : DONE;
            end
         end
         ACCESS: begin
            if ((wait_cnt == 4'd0) && (bus_ready || timed_out)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         region_mem <= 1'b0;
         err_flag   <= 1'b0;
         wait_cnt   <= 4'd0;
         stall_cnt  <= '0;
         bus_addr   <= '0;
         rdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_we    <= req_we;
                  lat_wdata <= req_wdata;
                  stall_cnt <= '0;
                  err_flag  <= !(in_mem || in_io);
                  if (in_mem) begin
                     region_mem <= 1'b1;
                     bus_addr   <= rel_mem;
                     wait_cnt   <= 4'(MEM_WAIT_STATES);
                  end else if (in_io) begin
                     region_mem <= 1'b0;
                     bus_addr   <= rel_io;
                     wait_cnt   <= 4'(IO_WAIT_STATES);
                  end
               end
            end
            ACCESS: begin
               // bus_ready is only looked at once the fixed wait states have elapsed.
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else if (bus_ready) begin
                  if (!lat_we) begin
                     rdata <= bus_data;
                  end
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
                  if (timed_out) begin
                     err_flag <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_access = (state == ACCESS);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign err       = done && err_flag;
   assign mem_cs    = in_access && region_mem;
   assign mem_we    = in_access && region_mem && lat_we;
   assign mem_oe    = in_access && region_mem && !lat_we;
   assign io_cs     = in_access && !region_mem;
   assign io_we     = in_access && !region_mem && lat_we;
   assign io_oe     = in_access && !region_mem && !lat_we;
   assign bus_data  = (in_access && lat_we) ? lat_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_interface_unit_ws.sv
// Scoreboard bench for bus_interface_unit_ws: directed requests push expected completions,
// a forked monitor pops and compares them whenever done is seen.
module tb_bus_interface_unit_ws;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        req_we;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  rdata;
   logic [15:0] bus_addr;
   wire  [7:0]  bus_data;
   logic        bus_ready;
   logic        mem_cs, mem_we, mem_oe;
   logic        io_cs, io_we, io_oe;
   logic        tb_drive;
   logic [7:0]  tb_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      string      name;
      logic       err;
      logic [7:0] rdata;
      int         done_cycle;
   } exp_t;

   exp_t exp_q[$];

   bus_interface_unit_ws dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .bus_addr  (bus_addr),
      .bus_data  (bus_data),
      .bus_ready (bus_ready),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_oe    (mem_oe),
      .io_cs     (io_cs),
      .io_we     (io_we),
      .io_oe     (io_oe)
   );

   assign bus_data = tb_drive ? tb_data : 8'bz;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Runs forever; every done pulse must match the oldest outstanding expectation.
   task automatic run_monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected done at cycle %0d: got done=1 expected none", cyc);
            end else begin
               e = exp_q.pop_front();
               check_output({e.name, " err"}, 32'(err), 32'(e.err));
               check_output({e.name, " rdata"}, 32'(rdata), 32'(e.rdata));
               check_output({e.name, " done cycle"}, 32'(cyc), 32'(e.done_cycle));
            end
         end
      end
   endtask

   // Called just after a negedge; returns at the negedge following the accepting edge.
   task automatic apply_stimulus(input string name, input logic we, input logic [15:0] addr,
                                 input logic [7:0] wdata, input logic push, input logic exp_err,
                                 input logic [7:0] exp_rdata, input int latency);
      exp_t e;
      if (push) begin
         e.name       = name;
         e.err        = exp_err;
         e.rdata      = exp_rdata;
         e.done_cycle = cyc + latency;
         exp_q.push_back(e);
      end
      req       = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
   endtask

   initial begin
      int cnt;
      exp_t e;
      reset     = 1'b1;
      req       = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      bus_ready = 1'b1;
      tb_drive  = 1'b0;
      tb_data   = '0;
      fork
         run_monitor();
      join_none

      repeat (3) @(negedge clk);
      check_output("reset busy", 32'(busy), 0);
      check_output("reset done", 32'(done), 0);
      check_output("reset err", 32'(err), 0);
      check_output("reset rdata", 32'(rdata), 0);
      check_output("reset bus_addr", 32'(bus_addr), 0);
      check_output("reset strobes", 32'({mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe}), 0);
      reset = 1'b0;
      @(negedge clk);

      // Memory load, zero wait states.
      tb_drive = 1'b1;
      tb_data  = 8'hA5;
      apply_stimulus("mem load", 1'b0, 16'h0045, 8'h00, 1'b1, 1'b0, 8'hA5, 2);
      check_output("mem load mem_cs", 32'(mem_cs), 1);
      check_output("mem load mem_oe", 32'(mem_oe), 1);
      check_output("mem load mem_we", 32'(mem_we), 0);
      check_output("mem load io strobes", 32'({io_cs, io_we, io_oe}), 0);
      check_output("mem load bus_addr", 32'(bus_addr), 32'h0005);
      check_output("mem load busy", 32'(busy), 1);
      @(negedge clk);
      check_output("mem load done strobes", 32'({mem_cs, mem_oe}), 0);
      check_output("mem load done busy", 32'(busy), 1);
      @(negedge clk);
      check_output("mem load idle busy", 32'(busy), 0);
      tb_drive = 1'b0;

      // IO store, one wait state.
      apply_stimulus("io store", 1'b1, 16'h0010, 8'h3C, 1'b1, 1'b0, 8'hA5, 3);
      check_output("io store io_cs c1", 32'(io_cs), 1);
      check_output("io store io_we", 32'(io_we), 1);
      check_output("io store io_oe", 32'(io_oe), 0);
      check_output("io store mem_cs", 32'(mem_cs), 0);
      check_output("io store bus_addr", 32'(bus_addr), 32'h0010);
      check_output("io store bus_data", 32'(bus_data), 32'h3C);
      @(negedge clk);
      check_output("io store io_cs c2", 32'(io_cs), 1);
      check_output("io store bus_data c2", 32'(bus_data), 32'h3C);
      @(negedge clk);
      check_output("io store done io_cs", 32'(io_cs), 0);
      check_output("io store bus released", 32'(bus_data !== 8'h3C), 1);
      @(negedge clk);

      // Memory load stretched by three low-ready cycles; a req during it must be ignored.
      tb_drive  = 1'b1;
      tb_data   = 8'h7E;
      bus_ready = 1'b0;
      apply_stimulus("stall load", 1'b0, 16'h0050, 8'h00, 1'b1, 1'b0, 8'h7E, 5);
      req      = 1'b1;
      req_addr = 16'h00C0;
      check_output("stall load mem_cs c1", 32'(mem_cs), 1);
      repeat (2) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check_output("stall load mem_cs c4", 32'(mem_cs), 1);
      check_output("stall load bus_addr", 32'(bus_addr), 32'h0010);
      bus_ready = 1'b1;
      @(negedge clk);
      tb_data = 8'hFF;
      @(negedge clk);
      tb_drive = 1'b0;

      // Timeout: ready never rises, rdata must keep 7E.
      bus_ready = 1'b0;
      apply_stimulus("timeout load", 1'b0, 16'h0060, 8'h00, 1'b1, 1'b1, 8'h7E, 17);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cnt += int'(mem_cs);
         @(negedge clk);
      end
      check_output("timeout access cycles", 32'(cnt), 16);
      check_output("timeout done strobes", 32'({mem_cs, mem_we, mem_oe}), 0);
      bus_ready = 1'b1;
      @(negedge clk);

      // Unmapped address: immediate error, no strobes.
      apply_stimulus("unmapped load", 1'b0, 16'h00C0, 8'h00, 1'b1, 1'b1, 8'h7E, 1);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cnt += int'(mem_cs | mem_we | mem_oe | io_cs | io_we | io_oe);
         @(negedge clk);
      end
      check_output("unmapped strobes", 32'(cnt), 0);

      // Back-to-back: req held through DONE is re-accepted after one IDLE cycle.
      e.name = "b2b first";  e.err = 1'b0; e.rdata = 8'h7E; e.done_cycle = cyc + 2;
      exp_q.push_back(e);
      e.name = "b2b second"; e.err = 1'b0; e.rdata = 8'h7E; e.done_cycle = cyc + 5;
      exp_q.push_back(e);
      req       = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h0041;
      req_wdata = 8'h11;
      @(negedge clk);
      check_output("b2b mem_we", 32'(mem_we), 1);
      check_output("b2b bus_addr", 32'(bus_addr), 32'h0001);
      repeat (2) @(negedge clk);
      check_output("b2b idle gap busy", 32'(busy), 0);
      @(negedge clk);
      req = 1'b0;
      check_output("b2b second mem_cs", 32'(mem_cs), 1);
      repeat (2) @(negedge clk);

      // Reset in the middle of an IO store must drop strobes immediately.
      apply_stimulus("aborted store", 1'b1, 16'h0020, 8'h5A, 1'b0, 1'b0, 8'h00, 0);
      check_output("abort io_cs before", 32'(io_cs), 1);
      #2 reset = 1'b1;
      #1;
      check_output("abort strobes", 32'({mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe}), 0);
      check_output("abort bus released", 32'(bus_data !== 8'h5A), 1);
      check_output("abort busy", 32'(busy), 0);
      check_output("abort rdata", 32'(rdata), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tb_drive = 1'b1;
      tb_data  = 8'h99;
      apply_stimulus("post reset load", 1'b0, 16'h0045, 8'h00, 1'b1, 1'b0, 8'h99, 2);
      check_output("post reset mem_oe", 32'(mem_oe), 1);
      repeat (2) @(negedge clk);
      tb_drive = 1'b0;

      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
      check_output("scoreboard drained", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_interface_unit_ws.md
Name: bus_interface_unit_ws

Overview:
- Next-generation bus interface unit between the CPU load/store/IN/OUT datapath and the external memory and I/O buses.
- Replaces the purely combinational decoder with a registered, FSM-driven transaction engine.
- Supports per-region programmable wait states, a peripheral ready/extension handshake, a stall timeout and unmapped-address error reporting.
- Strobes are always driven to known 0/1 values; X is never driven.

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 16, address width (CPU side and bus side)
IO_START_ADDR, 16'h0000, first address of the I/O region
IO_STOP_ADDR, 16'h003F, last address of the I/O region
MEM_START_ADDR, 16'h0040, first address of the data memory region
MEM_STOP_ADDR, 16'h00BF, last address of the data memory region
MEM_WAIT_STATES, 0, fixed wait cycles added to every memory access (0..15)
IO_WAIT_STATES, 1, fixed wait cycles added to every I/O access (0..15)
TIMEOUT_CYCLES, 16, maximum cycles bus_ready may stay low after the wait states (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  CPU requests a transaction; sampled only in IDLE
req_we  input  1  1 = store/OUT, 0 = load/IN
req_addr  input  ADDR_WIDTH  absolute address (direct immediate or indirect, already muxed by the CPU)
req_wdata  input  DATA_WIDTH  data to store
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done: unmapped address or timeout
rdata  output  DATA_WIDTH  load result, held until the next completed load
bus_addr  output  ADDR_WIDTH  region-relative bus address
bus_data  inout  DATA_WIDTH  shared bidirectional data bus
bus_ready  input  1  peripheral ready; 0 extends the access
mem_cs, mem_we, mem_oe  output  1 each  memory strobes
io_cs, io_we, io_oe  output  1 each  I/O strobes

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (asynchronous, immediate, including mid-transaction):
  - state = IDLE.
  - busy, done, err, and all cs/we/oe outputs = 0.
  - rdata = 0, bus_addr = 0, bus_data = Z.
- IDLE:
  - On a rising edge with req=1, latch req_we, req_addr and req_wdata, then decode.
  - Address in the MEM range: go to ACCESS, region = MEM, wait counter = MEM_WAIT_STATES.
  - Address in the IO range: go to ACCESS, region = IO, wait counter = IO_WAIT_STATES.
  - Address in neither range: go to DONE with err=1. No strobe is ever asserted.
  - If the ranges overlap, MEM takes priority.
- ACCESS:
  - Outputs registered from the latched request:
    - xx_cs = 1.
    - xx_we = latched we.
    - xx_oe = ~latched we.
    - bus_addr = latched addr - START of the selected region (relative for both MEM and IO).
  - The strobes of the unselected region stay 0.
  - bus_data = latched wdata when we=1; Z otherwise.
  - While the wait counter is nonzero, it decrements each cycle and bus_ready is ignored.
  - Once the counter is 0:
    - bus_ready=1 at an edge: complete. On a load, rdata <= bus_data at that edge. Go to DONE, err=0.
    - bus_ready=0: increment the stall counter. When it reaches TIMEOUT_CYCLES, go to DONE with err=1 and leave rdata unchanged.
- DONE:
  - Exactly one cycle.
  - done=1, err per the cause, busy=1.
  - All strobes are 0 and bus_data = Z.
  - Next state is IDLE.
- Latency with wait states W and immediate ready: req accepted at edge E0; ACCESS spans cycles E0..E0+W+1; done is high in the cycle after edge E0+W+1.
  - Total from acceptance to done = W+2 edges.
  - Unmapped address: done in the cycle after E0.
- Request rules:
  - req is ignored while busy; it is not queued.
  - req held high in the DONE cycle is accepted at the following edge (back-to-back), one IDLE cycle minimum.
- Bus address width: the subtraction is performed in ADDR_WIDTH bits; no wrap occurs within a valid range.
- No combinational path from req, req_addr or bus_ready to any output.

Test Plan:
- MEM_WAIT_STATES=0. Load req_addr=16'h0045 with bus_data=8'hA5 and bus_ready=1 → mem_cs=1 and mem_oe=1 for 1 cycle, bus_addr=16'h0005, done at edge+2, rdata=8'hA5, err=0, io_* all 0.
- IO_WAIT_STATES=1. Store (OUT) to 16'h0010 with wdata=8'h3C → io_cs=1 and io_we=1 for 2 cycles, bus_addr=16'h0010, bus_data=8'h3C during ACCESS and Z afterwards, done at edge+3.
- Memory load with bus_ready held low for 3 cycles after the wait states → ACCESS extended by 3 cycles, rdata captured on the first ready edge, err=0.
- bus_ready tied low, TIMEOUT_CYCLES=16 → done with err=1 after 16 stall cycles, rdata keeps its previous value, strobes drop to 0 in DONE.
- Load from unmapped address 16'h00C0 → done with err=1 in the cycle after the request, no cs/we/oe ever high, bus_data=Z.
- Assert reset in the middle of ACCESS on a store → all strobes 0 and bus_data=Z immediately, before the next edge. After release the unit is in IDLE with busy=0, and a new req completes normally.
